// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 32-bit LFSR bit stream: self-seeds from 32 bits, then predicts and checks.
// Loss-of-lock detection is compiled in only when LFSR_CHK_RELOCK_EN is defined.
module lfsr_seq_checker #(
    parameter int unsigned WINDOW   = 64,
    parameter int unsigned LOS_ERRS = 4,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             locked,
    output logic             bit_error,
    output logic             lock_lost,
    output logic [ERR_W-1:0] error_count
);

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_t;

    if (LOS_ERRS == 0 || WINDOW < LOS_ERRS || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_cfg
        $error("lfsr_seq_checker: WINDOW must be a power of two >= LOS_ERRS >= 1");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_s;
    logic [5:0]       r_seed_cnt;
    logic             r_locked;
    logic             r_bit_error;
    logic             r_lock_lost;
    logic [ERR_W-1:0] r_error_count;

    logic             w_acc;
    logic             w_fb;
    logic             w_seed_last;
    logic             w_seed_zero;
    logic             w_mismatch;
    logic             w_los;
    logic [31:0]      w_s_nxt;
    logic [5:0]       w_seed_cnt_nxt;
    logic [ERR_W-1:0] w_error_count_nxt;

    assign w_acc       = enable & bit_valid;
    assign w_fb        = r_s[31] ^ r_s[29] ^ r_s[25] ^ r_s[24];
    assign w_seed_last = (r_seed_cnt == 6'd31);
    assign w_seed_zero = ({r_s[30:0], bit_in} == 32'd0);
    assign w_mismatch  = w_acc & (r_state == CHECK) & (bit_in ^ w_fb);

`ifdef LFSR_CHK_RELOCK_EN
    localparam int unsigned WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned WERR_W = $clog2(LOS_ERRS + 1);

    logic [WIN_W-1:0]  r_win_cnt;
    logic [WIN_W-1:0]  w_win_cnt_nxt;
    logic [WERR_W-1:0] r_win_err;
    logic [WERR_W-1:0] w_win_err_nxt;
    logic              w_win_last;

    assign w_win_last = (r_win_cnt == WIN_W'(WINDOW - 1));
    assign w_los      = w_mismatch & (r_win_err == WERR_W'(LOS_ERRS - 1));

    // Loss clears the window exactly like a rollover, so both share one branch.
    always_comb begin
        w_win_cnt_nxt = r_win_cnt;
        w_win_err_nxt = r_win_err;
        if (w_acc && r_state == CHECK) begin
            if (w_los || w_win_last) begin
                w_win_cnt_nxt = '0;
                w_win_err_nxt = '0;
            end else begin
                w_win_cnt_nxt = r_win_cnt + WIN_W'(1);
                w_win_err_nxt = r_win_err + WERR_W'(w_mismatch);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else begin
            r_win_cnt <= w_win_cnt_nxt;
            r_win_err <= w_win_err_nxt;
        end
    end
`else
    assign w_los = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= SEED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEED:    if (w_acc && w_seed_last && !w_seed_zero) w_state_nxt = CHECK;
            CHECK:   if (w_los) w_state_nxt = SEED;
            default: w_state_nxt = SEED;
        endcase
    end

    // Predicted bit is shifted in during CHECK so a single corrupted bit costs one error.
    always_comb begin
        w_s_nxt           = r_s;
        w_seed_cnt_nxt    = r_seed_cnt;
        w_error_count_nxt = r_error_count;
        if (w_acc) begin
            if (r_state == SEED) begin
                w_s_nxt        = {r_s[30:0], bit_in};
                w_seed_cnt_nxt = w_seed_last ? 6'd0 : r_seed_cnt + 6'd1;
            end else begin
                w_s_nxt = {r_s[30:0], w_fb};
                if (w_mismatch && r_error_count != '1) begin
                    w_error_count_nxt = r_error_count + ERR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s           <= '0;
            r_seed_cnt    <= '0;
            r_locked      <= 1'b0;
            r_bit_error   <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_error_count <= '0;
        end else begin
            r_s           <= w_s_nxt;
            r_seed_cnt    <= w_seed_cnt_nxt;
            r_locked      <= (w_state_nxt == CHECK);
            r_bit_error   <= w_mismatch;
            r_lock_lost   <= w_los;
            r_error_count <= w_error_count_nxt;
        end
    end

    assign locked      = r_locked;
    assign bit_error   = r_bit_error;
    assign lock_lost   = r_lock_lost;
    assign error_count = r_error_count;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: bit-history reference model, scenario tasks and a randomized run.
module tb_lfsr_seq_checker;

    localparam int unsigned WINDOW   = 64;
    localparam int unsigned LOS_ERRS = 4;
    localparam int unsigned ERR_W    = 5;
    localparam int unsigned ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             locked;
    logic             bit_error;
    logic             lock_lost;
    logic [ERR_W-1:0] error_count;

    int total = 0;
    int bad   = 0;

    lfsr_seq_checker #(
        .WINDOW  (WINDOW),
        .LOS_ERRS(LOS_ERRS),
        .ERR_W   (ERR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .locked     (locked),
        .bit_error  (bit_error),
        .lock_lost  (lock_lost),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    // Generator: b[n] = b[n-32]^b[n-30]^b[n-26]^b[n-25], history starts all ones.
    bit g[$];

    task automatic gen_reset();
        g.delete();
        for (int i = 0; i < 32; i++) g.push_back(1'b1);
    endtask

    function automatic bit gen_next();
        bit nb;
        nb = g[0] ^ g[2] ^ g[6] ^ g[7];
        g.push_back(nb);
        void'(g.pop_front());
        return nb;
    endfunction

    // Reference model: hist holds the last 32 seed/predicted bits, oldest first.
    bit hist[$];
    bit m_locked;
    bit m_berr;
    bit m_lost;
    int m_seed;
    int m_errs;
    int m_win;
    int m_werr;

    function automatic logic [ERR_W+2:0] got();
        return {locked, bit_error, lock_lost, error_count};
    endfunction

    function automatic logic [ERR_W+2:0] want();
        return {m_locked, m_berr, m_lost, ERR_W'(m_errs)};
    endfunction

    task automatic step(input logic rst_n, input logic en, input logic v, input logic b);
        bit pred;
        bit any1;
        reset_n   = rst_n;
        enable    = en;
        bit_valid = v;
        bit_in    = b;
        m_berr = 1'b0;
        m_lost = 1'b0;
        if (!rst_n) begin
            m_locked = 1'b0;
            m_seed   = 0;
            m_errs   = 0;
            m_win    = 0;
            m_werr   = 0;
            hist.delete();
        end else if (en && v) begin
            if (!m_locked) begin
                hist.push_back(b);
                if (hist.size() > 32) void'(hist.pop_front());
                m_seed++;
                if (m_seed == 32) begin
                    m_seed = 0;
                    any1 = 1'b0;
                    foreach (hist[i]) any1 |= hist[i];
                    m_locked = any1;
                end
            end else begin
                pred = hist[0] ^ hist[2] ^ hist[6] ^ hist[7];
                hist.push_back(pred);
                void'(hist.pop_front());
                if (b != pred) begin
                    m_berr = 1'b1;
                    if (m_errs < ERR_MAX) m_errs++;
                    m_werr++;
                end
`ifdef LFSR_CHK_RELOCK_EN
                if (m_werr == LOS_ERRS) begin
                    m_lost   = 1'b1;
                    m_locked = 1'b0;
                    m_seed   = 0;
                    m_win    = 0;
                    m_werr   = 0;
                    hist.delete();
                end else if (m_win == WINDOW - 1) begin
                    m_win  = 0;
                    m_werr = 0;
                end else begin
                    m_win++;
                end
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        gen_reset();
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (got() !== {3'b000, ERR_W'(0)}) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", got(), {3'b000, ERR_W'(0)});
        end
        gen_reset();
    endtask

    task automatic test_lock_stream();
        do_reset();
        for (int i = 0; i < 288; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next());
            total++;
            if (got() !== want()) begin
                bad++;
                $display("FAIL lock_stream i=%0d got=%h want=%h", i, got(), want());
            end
            if (i == 30) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", locked); end
            end
            if (i == 31) begin
                total++;
                if (locked !== 1'b1) begin bad++; $display("FAIL lock_time got=%b want=1", locked); end
            end
        end
        total++;
        if (error_count !== ERR_W'(0)) begin
            bad++;
            $display("FAIL lock_clean_count got=%0d want=0", error_count);
        end
    endtask

    task automatic test_single_error();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 288; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next() ^ (i == 100));
            pulses += int'(bit_error);
            total++;
            if (got() !== want()) begin
                bad++;
                $display("FAIL single_err i=%0d got=%h want=%h", i, got(), want());
            end
        end
        total++;
        if (pulses != 1 || error_count !== ERR_W'(1) || locked !== 1'b1) begin
            bad++;
            $display("FAIL single_err_summary got pulses=%0d cnt=%0d locked=%b want 1/1/1",
                     pulses, error_count, locked);
        end
    endtask

    task automatic test_zero_seed();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            total++;
            if (locked !== 1'b0 || got() !== want()) begin
                bad++;
                $display("FAIL zero_seed i=%0d got=%h want=%h", i, got(), want());
            end
        end
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next());
            total++;
            if (got() !== want() || locked !== (i >= 31)) begin
                bad++;
                $display("FAIL zero_then_valid i=%0d got=%h want=%h", i, got(), want());
            end
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 1'b1, gen_next());
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'(i));
            total++;
            if (bit_error !== 1'b0 || got() !== want()) begin
                bad++;
                $display("FAIL enable_hold i=%0d got=%h want=%h", i, got(), want());
            end
        end
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next());
            total++;
            if (got() !== want()) begin
                bad++;
                $display("FAIL enable_resume i=%0d got=%h want=%h", i, got(), want());
            end
        end
        total++;
        if (error_count !== ERR_W'(0) || locked !== 1'b1) begin
            bad++;
            $display("FAIL enable_summary got cnt=%0d locked=%b want 0/1", error_count, locked);
        end
    endtask

    task automatic test_reset_midcheck();
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, gen_next());
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next() ^ (i == 3 || i == 8 || i == 13));
            total++;
            if (got() !== want()) begin
                bad++;
                $display("FAIL midcheck_errs i=%0d got=%h want=%h", i, got(), want());
            end
        end
        total++;
        if (error_count !== ERR_W'(3)) begin
            bad++;
            $display("FAIL midcheck_count got=%0d want=3", error_count);
        end
        step(1'b0, 1'b1, 1'b1, gen_next());
        total++;
        if (locked !== 1'b0 || error_count !== ERR_W'(0) || bit_error !== 1'b0) begin
            bad++;
            $display("FAIL midcheck_reset got locked=%b cnt=%0d err=%b want 0/0/0",
                     locked, error_count, bit_error);
        end
    endtask

`ifdef LFSR_CHK_RELOCK_EN
    task automatic test_relock();
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, gen_next());
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next() ^ (i == 2 || i == 5 || i == 9 || i == 14));
            total++;
            if (got() !== want() || lock_lost !== (i == 14) || locked !== (i < 14)) begin
                bad++;
                $display("FAIL relock_loss i=%0d got=%h want=%h", i, got(), want());
            end
        end
        for (int i = 0; i < 42; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next());
            total++;
            if (got() !== want() || locked !== (i >= 31)) begin
                bad++;
                $display("FAIL relock_seed i=%0d got=%h want=%h", i, got(), want());
            end
        end
        total++;
        if (error_count !== ERR_W'(4)) begin
            bad++;
            $display("FAIL relock_count got=%0d want=4", error_count);
        end
    endtask

    task automatic test_window();
        int lost = 0;
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, gen_next());
        for (int k = 0; k < 140; k++) begin
            step(1'b1, 1'b1, 1'b1, gen_next() ^ (k == 50 || k == 55 || k == 60 || k == 64 ||
                                                  k == 100 || k == 110 || k == 127));
            lost += int'(lock_lost);
            total++;
            if (got() !== want() || lock_lost !== (k == 127)) begin
                bad++;
                $display("FAIL window k=%0d got=%h want=%h", k, got(), want());
            end
        end
        total++;
        if (lost != 1 || error_count !== ERR_W'(7)) begin
            bad++;
            $display("FAIL window_summary got lost=%0d cnt=%0d want 1/7", lost, error_count);
        end
    endtask
`else
    task automatic test_no_relock();
        int lost = 0;
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, gen_next());
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 1'b1, gen_next() ^ (i == 3 || i == 8 || i == 13 || i == 20));
            lost += int'(lock_lost);
            total++;
            if (got() !== want()) begin
                bad++;
                $display("FAIL norelock i=%0d got=%h want=%h", i, got(), want());
            end
        end
        total++;
        if (lost != 0 || locked !== 1'b1 || error_count !== ERR_W'(4)) begin
            bad++;
            $display("FAIL norelock_summary got lost=%0d locked=%b cnt=%0d want 0/1/4",
                     lost, locked, error_count);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b1, ~gen_next());
            total++;
            if (got() !== want()) begin
                bad++;
                $display("FAIL saturate i=%0d got=%h want=%h", i, got(), want());
            end
        end
        total++;
        if (error_count !== ERR_W'(ERR_MAX) || locked !== 1'b1) begin
            bad++;
            $display("FAIL saturate_summary got cnt=%0d locked=%b want %0d/1",
                     error_count, locked, ERR_MAX);
        end
    endtask
`endif

    task automatic test_random();
        logic rn;
        logic en;
        logic v;
        logic b;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 999) != 0);
            en = ($urandom_range(0, 7) != 0);
            v  = ($urandom_range(0, 7) != 0);
            b  = 1'($urandom_range(0, 1));
            if (rn && en && v) b = gen_next() ^ ($urandom_range(0, 39) == 0);
            step(rn, en, v, b);
            total++;
            if (got() !== want()) begin
                bad++;
                $display("FAIL random i=%0d got=%h want=%h", i, got(), want());
            end
        end
    endtask

    initial begin
        gen_reset();
        test_reset();
        test_lock_stream();
        test_single_error();
        test_zero_seed();
        test_enable_hold();
        test_reset_midcheck();
`ifdef LFSR_CHK_RELOCK_EN
        test_relock();
        test_window();
`else
        test_no_relock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Receive-side companion to the 32-bit LFSR random-bit generator. Consumes the serial bit stream (one bit per accepted cycle), self-seeds its local LFSR from the first 32 received bits, then predicts and checks every following bit using the same feedback polynomial. Reports lock status, per-bit mismatches and a saturating error count. Sits on the hash test/bring-up path to prove the random sequence feeding the hash core is intact.

## Interface
- WINDOW, 64: checked bits per loss-of-lock window (power of two, ≥ LOS_ERRS).
- LOS_ERRS, 4: mismatches within one window that declare loss of lock.
- ERR_W, 16: width of error_count.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  when low, bit_valid is ignored and all state holds.
- bit_valid  in  1  bit_in is offered this cycle.
- bit_in  in  1  received serial bit.
- locked  out  1  high while in CHECK.
- bit_error  out  1  one-cycle pulse: the previous accepted bit mismatched.
- lock_lost  out  1  one-cycle pulse: loss of lock declared.
- error_count  out  ERR_W  total mismatches since reset, saturating.

## Operation
- Bit accepted when enable & bit_valid.
- Local register s[31:0]; feedback p = s[31]^s[29]^s[25]^s[24]; shift is s <= {s[30:0], x}.
- State SEED: each accepted bit: s <= {s[30:0], bit_in}; seed_cnt++ (6-bit). The 32nd accepted bit moves to CHECK, except when the resulting s is all zeros (illegal LFSR state): stay in SEED, seed_cnt <= 0.
- State CHECK: each accepted bit: mismatch = bit_in ^ p; s <= {s[30:0], p}. The predicted bit is always shifted in, never the received one, so one corrupted bit yields exactly one error.
- Mismatch: bit_error pulses; error_count += 1 unless already all ones; win_err += 1.
- Window: win_cnt counts accepted bits 0..WINDOW-1. On the bit with win_cnt == WINDOW-1: win_cnt <= 0 and win_err <= 0.
- Loss of lock: a mismatch that brings win_err to LOS_ERRS. Pulse lock_lost; go to SEED with seed_cnt, win_cnt, win_err <= 0. The loss bit is not used as seed. Loss takes priority over a simultaneous window rollover.
- error_count survives relock; only reset clears it.

## Timing
- All outputs are registered. Reset values: locked 0, bit_error 0, lock_lost 0, error_count 0, state SEED, s 0, all counters 0.
- locked rises in the cycle after the 32nd seed bit is accepted.
- bit_error and error_count update in the cycle after the mismatching bit is accepted.
- lock_lost pulses and locked falls in the cycle after the loss bit is accepted.
- Relock takes at least 32 further accepted bits.
- With bit_valid low or enable low, bit_error and lock_lost are 0 and nothing else changes.
- A reset_n low sample at any state (including mid-seed or mid-window) gives reset values on the next cycle; the bit offered that cycle is discarded.
- Throughput: one bit per cycle, no back-pressure.

## Configuration
- LFSR_CHK_RELOCK_EN defined: loss-of-lock detection is compiled in, exactly as described above.
- Not defined: win_cnt and win_err are removed and lock_lost is tied to 0. Once in CHECK the block stays there until reset; mismatches still pulse bit_error and increment error_count.

## Test plan
- Reset, then feed 288 consecutive generator bits from its all-ones reset state -> locked = 1 one cycle after bit 32; error_count = 0 at the end.
- Same stream with checked bit 100 inverted -> exactly one bit_error pulse; error_count = 1; locked stays 1.
- (RELOCK_EN) Invert 4 bits within one 64-bit window -> lock_lost pulse and locked = 0 after the 4th; after 32 more clean bits locked = 1; error_count = 4.
- Feed 32 zeros, then a valid stream -> locked stays 0 through the zeros; locks 32 valid bits later.
- Hold enable = 0 for 10 cycles mid-CHECK while toggling bit_in, then resume -> no errors; checking continues in sequence.
- Assert reset_n = 0 for 1 cycle mid-CHECK with error_count = 3 -> next cycle locked = 0, error_count = 0. Without RELOCK_EN, 4 errors in a window -> locked stays 1, lock_lost never asserts, error_count = 4.
